mantissa_divider: RTL and testbench



---
 rtl/mantissa_divider_if.sv | 24 ++
 rtl/mantissa_divider.sv | 80 ++++++++
 tb/tb_mantissa_divider.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mantissa_divider_if.sv
// Start/done handshake and operand/result bundle for the mantissa divider.
// master = FP control FSM, slave = divider.
interface mantissa_divider_if #(
    parameter int WIDTH = 23
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/mantissa_divider.sv
// Sequential unsigned mantissa divider using repeated subtraction.
// Results are published only when an operation completes.
module mantissa_divider #(
    parameter int WIDTH = 23
) (
    input logic               clk,
    input logic               reset_n,
    mantissa_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] q_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            rem_r           <= '0;
            div_r           <= '0;
            q_r             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            // Divide by zero completes immediately with a saturated quotient
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                            state           <= DONE;
                        end else begin
                            rem_r           <= bus.dividend;
                            div_r           <= bus.divisor;
                            q_r             <= '0;
                            bus.div_by_zero <= 1'b0;
                            bus.busy        <= 1'b1;
                            state           <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (rem_r >= div_r) begin
                        rem_r <= rem_r - div_r;
                        q_r   <= q_r + WIDTH'(1);
                    end else begin
                        bus.quotient  <= q_r;
                        bus.remainder <= rem_r;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mantissa_divider.sv
// Directed bench for mantissa_divider with hand-computed results.
// Outputs are sampled on the falling clock edge.
module tb_mantissa_divider;
    localparam int W = 23;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   nbusy;

    mantissa_divider_if #(.WIDTH(W)) bus ();

    mantissa_divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit,
                             output int busy_n);
        int n;
        n      = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            if (bus.busy === 1'b1) busy_n++;
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] q,
                          input logic [W-1:0] r, input int cyc);
        launch(a, b);
        wait_done(tag, 200, nbusy);
        check({tag, "_q"}, 32'(bus.quotient), 32'(q));
        check({tag, "_r"}, 32'(bus.remainder), 32'(r));
        check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, 32'd0);
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'(cyc));
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        reset_n = 1'b1;

        run_op("d100_7", 23'd100, 23'd7, 23'd14, 23'd2, 15);
        run_op("d5_9", 23'd5, 23'd9, 23'd0, 23'd5, 1);
        run_op("d0_3", 23'd0, 23'd3, 23'd0, 23'd0, 1);

        launch(23'd9, 23'd0);
        check("dz_done_lat", {31'd0, bus.done}, 32'd1);
        check("dz_busy", {31'd0, bus.busy}, 32'd0);
        check("dz_q", 32'(bus.quotient), 32'h7FFFFF);
        check("dz_r", 32'(bus.remainder), 32'd9);
        check("dz_flag", {31'd0, bus.div_by_zero}, 32'd1);
        @(negedge clk);
        check("dz_done_pulse", {31'd0, bus.done}, 32'd0);
        check("dz_flag_hold", {31'd0, bus.div_by_zero}, 32'd1);

        run_op("d8_4", 23'd8, 23'd4, 23'd2, 23'd0, 3);
        run_op("dmax", 23'h7FFFFF, 23'h7FFFFF, 23'd1, 23'd0, 2);
        run_op("d40_1", 23'd40, 23'd1, 23'd40, 23'd0, 41);

        // Start during RUN must be ignored
        launch(23'd100, 23'd7);
        repeat (3) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 23'd50;
        bus.divisor  = 23'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ign", 200, nbusy);
        check("ign_q", 32'(bus.quotient), 32'd14);
        check("ign_r", 32'(bus.remainder), 32'd2);
        repeat (5) @(negedge clk);
        check("hold_q", 32'(bus.quotient), 32'd14);
        check("hold_r", 32'(bus.remainder), 32'd2);
        check("hold_busy", {31'd0, bus.busy}, 32'd0);
        check("hold_done", {31'd0, bus.done}, 32'd0);

        // Reset mid-operation abandons the division
        launch(23'd100, 23'd7);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mrst_q", 32'(bus.quotient), 32'd0);
        check("mrst_r", 32'(bus.remainder), 32'd0);
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_done", {31'd0, bus.done}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
            end
            check("mrst_quiet", 32'(seen), 32'd0);
        end
        run_op("d20_6", 23'd20, 23'd6, 23'd3, 23'd2, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
